// File: rtl/lc_pkg.sv
// Shared definitions for the hit tagger: channel/timestamp sizing, per-channel
// FSM state encoding and the tagged-event record.
package lc_pkg;

  localparam int N_CHANNELS = 24;
  localparam int TS_WIDTH   = 48;
  localparam int CH_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PEND = 2'd2
  } lc_state_t;

  typedef struct packed {
    logic [CH_W-1:0]     chan;
    logic                lc;
    logic [TS_WIDTH-1:0] ts;
  } lc_evt_t;

endpackage

// File: rtl/lc_hit_chan.sv
// One trigger channel: rising-edge hit detect, timestamp capture and the
// LC wait window that classifies the hit as HLC or SLC.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   trig              discriminator level for this channel
//   local_coinc       LC flag for this channel
//   ltc               local time counter, captured on a hit
//   lc_window_width   LC window length, sampled on a hit
//   grant             arbiter has taken this channel's pending hit
//   pend              channel holds a tagged hit awaiting grant
//   lc, ts            tag and timestamp of the pending hit
//   drop              a hit arrived while the channel was busy
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no hit in flight
// ST_WAIT | hit captured, counting down the window for local_coinc
// ST_PEND | hit tagged, waiting for the arbiter
module lc_hit_chan
  import lc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  input  logic                local_coinc,
  input  logic [TS_WIDTH-1:0] ltc,
  input  logic [15:0]         lc_window_width,
  input  logic                grant,
  output logic                pend,
  output logic                lc,
  output logic [TS_WIDTH-1:0] ts,
  output logic                drop
);

  lc_state_t           state_q, state_d;
  logic                trig_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                lc_q, lc_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                hit, free;

  assign hit = trig & ~trig_d;
  // A grant in the same cycle frees the channel, so a new hit is accepted.
  assign free = (state_q == ST_IDLE) || ((state_q == ST_PEND) && grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_d  <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lc_q    <= 1'b0;
      ts_q    <= '0;
    end else begin
      trig_d  <= trig;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lc_q    <= lc_d;
      ts_q    <= ts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lc_d    = lc_q;
    ts_d    = ts_q;
    drop    = 1'b0;
    if (hit && free) begin
      ts_d = ltc;
      if (local_coinc) begin
        state_d = ST_PEND;
        lc_d    = 1'b1;
      end else if (lc_window_width == 16'd0) begin
        state_d = ST_PEND;
        lc_d    = 1'b0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = lc_window_width;
      end
    end else begin
      drop = hit;
      case (state_q)
        ST_WAIT: begin
          if (local_coinc) begin
            state_d = ST_PEND;
            lc_d    = 1'b1;
          end else if (cnt_q == 16'd1) begin
            state_d = ST_PEND;
            lc_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_PEND: begin
          if (grant) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign pend = (state_q == ST_PEND);
  assign lc   = lc_q;
  assign ts   = ts_q;

endmodule

// File: rtl/lc_hit_tagger.sv
// Tags every channel hit as HLC/SLC and serializes the tagged hits from all
// channels onto a single valid/ready event stream with round-robin arbitration.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ltc               free-running local time counter
//   lc_window_width   LC wait window in cycles
//   trig              per-channel discriminator levels
//   local_coinc       per-channel LC flags
//   evt_valid/ready   event handshake
//   evt_chan/lc/ts    event payload
//   drop_cnt          saturating count of hits lost to busy channels
module lc_hit_tagger
  import lc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TS_WIDTH-1:0]   ltc,
  input  logic [15:0]           lc_window_width,
  input  logic [N_CHANNELS-1:0] trig,
  input  logic [N_CHANNELS-1:0] local_coinc,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [CH_W-1:0]       evt_chan,
  output logic                  evt_lc,
  output logic [TS_WIDTH-1:0]   evt_ts,
  output logic [15:0]           drop_cnt
);

  logic [N_CHANNELS-1:0] pend, ch_lc, drop, grant;
  logic [TS_WIDTH-1:0]   ch_ts [N_CHANNELS];

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    lc_hit_chan u_chan (
      .clk             (clk),
      .rst             (rst),
      .trig            (trig[g]),
      .local_coinc     (local_coinc[g]),
      .ltc             (ltc),
      .lc_window_width (lc_window_width),
      .grant           (grant[g]),
      .pend            (pend[g]),
      .lc              (ch_lc[g]),
      .ts              (ch_ts[g]),
      .drop            (drop[g])
    );
  end

  logic [CH_W-1:0] rr_ptr;
  logic            load, found;
  lc_evt_t         win, evt_q;
  logic [16:0]     drop_sum;

  assign load = ~evt_valid | evt_ready;

  // Search starts one past the last granted channel and wraps.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] sel;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      idx = (int'(rr_ptr) + 1 + k) % N_CHANNELS;
      sel = CH_W'(idx);
      if (!found && pend[sel]) begin
        found    = 1'b1;
        win.chan = sel;
        win.lc   = ch_lc[sel];
        win.ts   = ch_ts[sel];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && found) grant[win.chan] = 1'b1;
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'($countones(drop));

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_q     <= '0;
      rr_ptr    <= CH_W'(N_CHANNELS - 1);
      drop_cnt  <= '0;
    end else begin
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_q  <= win;
          rr_ptr <= win.chan;
        end
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign evt_chan = evt_q.chan;
  assign evt_lc   = evt_q.lc;
  assign evt_ts   = evt_q.ts;

endmodule

// File: tb/tb_lc_hit_tagger.sv
// Self-checking bench for lc_hit_tagger: expected events are queued when
// hits are driven and compared as the DUT hands them over.
module tb_lc_hit_tagger;
  import lc_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [TS_WIDTH-1:0]   ltc;
  logic [15:0]           lc_window_width;
  logic [N_CHANNELS-1:0] trig, local_coinc;
  logic                  evt_valid, evt_ready, evt_lc;
  logic [CH_W-1:0]       evt_chan;
  logic [TS_WIDTH-1:0]   evt_ts;
  logic [15:0]           drop_cnt;

  lc_hit_tagger dut (
    .clk             (clk),
    .rst             (rst),
    .ltc             (ltc),
    .lc_window_width (lc_window_width),
    .trig            (trig),
    .local_coinc     (local_coinc),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_chan        (evt_chan),
    .evt_lc          (evt_lc),
    .evt_ts          (evt_ts),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  int      n_tests = 0;
  int      n_fail  = 0;
  int      xfer_cnt = 0;
  lc_evt_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      ltc = ltc + 48'd1;
    end
  endtask

  task automatic expect_evt(input int ch, input logic lcv);
    lc_evt_t e;
    e.chan = CH_W'(ch);
    e.lc   = lcv;
    e.ts   = ltc;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb_q.size() != 0 && b < 300) begin
      tick();
      b++;
    end
    check("drain", sb_q.size(), 0);
    sb_q.delete();
    tick(5);
  endtask

  // Monitor: scoreboard compare on each transfer, stability under backpressure.
  initial begin
    lc_evt_t             e;
    logic                hold_p;
    logic [CH_W-1:0]     hc;
    logic                hl;
    logic [TS_WIDTH-1:0] hts;
    hold_p = 1'b0;
    hc = '0; hl = 1'b0; hts = '0;
    forever begin
      @(negedge clk);
      if (hold_p) begin
        check("hold_valid", evt_valid, 1);
        check("hold_chan", evt_chan, hc);
        check("hold_lc", evt_lc, hl);
        check("hold_ts", evt_ts, hts);
      end
      hold_p = evt_valid && !evt_ready && !rst;
      hc = evt_chan; hl = evt_lc; hts = evt_ts;
      if (evt_valid && evt_ready && !rst) begin
        xfer_cnt++;
        check("evt_expected", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("evt_chan", evt_chan, e.chan);
          check("evt_lc", evt_lc, e.lc);
          check("evt_ts", evt_ts, e.ts);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, bench not finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; ltc = '0; lc_window_width = 16'd9;
    trig = '0; local_coinc = '0; evt_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_chan", evt_chan, 0);
    check("rst_lc", evt_lc, 0);
    check("rst_ts", evt_ts, 0);
    check("rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick(3);

    // Single HLC, coincidence four cycles after the hit
    ltc = 48'd100;
    trig[3] = 1'b1;
    expect_evt(3, 1'b1);
    tick(4);
    local_coinc[3] = 1'b1;
    tick();
    local_coinc = '0;
    tick();
    trig = '0;
    drain();
    @(negedge clk);
    check("hlc_drop", drop_cnt, 0);

    // Window boundary: no LC, LC at t+9, LC at t+10
    for (int c = 0; c < 3; c++) begin
      trig[5] = 1'b1;
      expect_evt(5, (c == 1));
      tick();
      trig[5] = 1'b0;
      tick(8);
      if (c == 1) local_coinc[5] = 1'b1;
      tick();
      local_coinc = '0;
      if (c == 2) local_coinc[5] = 1'b1;
      tick();
      local_coinc = '0;
      drain();
    end

    // Busy drop: second rise lands while the channel is still waiting
    trig[2] = 1'b1;
    expect_evt(2, 1'b0);
    tick(2);
    trig[2] = 1'b0;
    tick(2);
    trig[2] = 1'b1;
    tick(2);
    trig[2] = 1'b0;
    drain();
    @(negedge clk);
    check("drop_one", drop_cnt, 1);

    // Walking one, with and without coincidence
    for (int lcv = 1; lcv >= 0; lcv--) begin
      trig = '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        trig[i] = 1'b1;
        local_coinc = '0;
        local_coinc[i] = (lcv == 1);
        expect_evt(i, (lcv == 1));
        tick();
      end
      local_coinc = '0;
      drain();
      trig = '0;
      tick(2);
    end

    // Arbitration under backpressure, twice
    for (int rep = 0; rep < 2; rep++) begin
      evt_ready = 1'b0;
      trig[0] = 1'b1; trig[7] = 1'b1; trig[23] = 1'b1;
      local_coinc[0] = 1'b1; local_coinc[7] = 1'b1; local_coinc[23] = 1'b1;
      expect_evt(0, 1'b1);
      expect_evt(7, 1'b1);
      expect_evt(23, 1'b1);
      tick();
      local_coinc = '0;
      tick(19);
      @(negedge clk);
      check("arb_valid", evt_valid, 1);
      check("arb_first", evt_chan, 0);
      tick();
      base = xfer_cnt;
      evt_ready = 1'b1;
      tick(3);
      check("arb_b2b", xfer_cnt - base, 3);
      trig = '0;
      drain();
    end

    // Reset with hits in flight
    evt_ready = 1'b0;
    trig[4] = 1'b1; trig[6] = 1'b1; trig[8] = 1'b1;
    local_coinc[4] = 1'b1;
    tick();
    local_coinc = '0;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trig = '0;
    @(negedge clk);
    check("midrst_valid", evt_valid, 0);
    check("midrst_drop", drop_cnt, 0);
    tick();
    base = xfer_cnt;
    evt_ready = 1'b1;
    tick(20);
    check("midrst_no_evt", xfer_cnt - base, 0);

    // Drop counter: 24 per cycle, then saturation
    lc_window_width = 16'hFFFF;
    trig = '1;
    tick();
    for (int r = 0; r < 2920; r++) begin
      trig = '0;
      tick();
      trig = '1;
      tick();
      if (r < 2) begin
        @(negedge clk);
        check("drop_multi", drop_cnt, 24 * (r + 1));
      end
    end
    @(negedge clk);
    check("drop_sat", drop_cnt, 16'hFFFF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    trig = '0;
    @(negedge clk);
    check("satrst_valid", evt_valid, 0);
    check("satrst_drop", drop_cnt, 0);
    tick();
    base = xfer_cnt;
    tick(30);
    check("satrst_no_evt", xfer_cnt - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
